// File: rtl/threewire_cmd_queue_pkg.sv
// Purpose : shared definitions for the threewire command sequencer (FSM states, entry width).
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package threewire_cmd_queue_pkg;

  // Sequencer states; encodings are fixed so they read the same in every dump.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } tw_state_t;

  // Command FIFO entry: {wr, addr, data}.
  function automatic int cmd_entry_bits(input int addr_bits, input int data_bits);
    return 1 + addr_bits + data_bits;
  endfunction

endpackage

// File: rtl/threewire_cmd_queue_sync_fifo.sv
// Purpose : single-clock FIFO with occupancy count; head is presented combinationally (0 when empty).
// Latency : a push is visible at the head the cycle after it is written.
// Backpressure: push refused when full unless a same-cycle pop frees the slot; pop ignored when empty.
//
// Ports: in_clk/in_rst_n clock and async active-low reset; in_push/in_push_data write side;
//        in_pop read side; out_head head entry; out_count/out_full/out_empty occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_push,
  input  logic [WIDTH-1:0]         in_push_data,
  input  logic                     in_pop,
  output logic [WIDTH-1:0]         out_head,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_full,
  output logic                     out_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign out_count = wr_ptr - rd_ptr;
  assign out_empty = (wr_ptr == rd_ptr);
  assign out_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = in_pop && !out_empty;
  assign do_push = in_push && (!out_full || do_pop);

  assign out_head = out_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge in_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= in_push_data;
  end

endmodule

// File: rtl/threewire_cmd_queue.sv
// Purpose : buffers register read/write commands and issues them one at a time to the threewire master.
// Latency : command pushed into an empty queue at T is held at T+1, start pulse at T+2.
// Backpressure: out_cmd_ready low when the command FIFO is full; reads wait for a free response slot.
//
// Ports: in_cmd_* host command side (valid/ready); out_rsp_*/in_rsp_ready read responses;
//        out_tw_* / in_tw_* master control and status; out_busy activity; out_timeout_err sticky error.
module threewire_cmd_queue
  import threewire_cmd_queue_pkg::*;
#(
  parameter int ADDR_BITS     = 10,
  parameter int DATA_BITS     = 32,
  parameter int CMD_DEPTH     = 8,
  parameter int RSP_DEPTH     = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_cmd_valid,
  output logic                 out_cmd_ready,
  input  logic                 in_cmd_wr,
  input  logic [ADDR_BITS-1:0] in_cmd_addr,
  input  logic [DATA_BITS-1:0] in_cmd_data,
  output logic                 out_rsp_valid,
  input  logic                 in_rsp_ready,
  output logic [DATA_BITS-1:0] out_rsp_data,
  output logic                 out_tw_start,
  output logic                 out_tw_mode_wr,
  output logic [ADDR_BITS-1:0] out_tw_addr,
  output logic [DATA_BITS-1:0] out_tw_wr_data,
  input  logic [DATA_BITS-1:0] in_tw_rd_data,
  input  logic                 in_tw_in_progress,
  output logic                 out_busy,
  output logic                 out_timeout_err
);

  localparam int CMD_W  = cmd_entry_bits(ADDR_BITS, DATA_BITS);
  localparam int TMO_W  = $clog2(START_TIMEOUT + 1);
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

  tw_state_t          state;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CMD_W-1:0]   cmd_head;
  logic [CMD_CW-1:0]  cmd_count;
  logic               cmd_full;
  logic               cmd_empty;
  logic [RSP_CW-1:0]  rsp_count;
  logic               rsp_full;
  logic               rsp_empty;
  logic               head_wr;
  logic               rsp_slot_free;
  logic               issue;
  logic               cmd_push;
  logic               rsp_push;

  assign cmd_push = in_cmd_valid && !cmd_full;
  assign head_wr  = cmd_head[CMD_W-1];

  // Only one transfer is ever in flight and a read fills its slot in CAPTURE before
  // the FSM is back in IDLE, so in IDLE the pending-read reservation is always zero
  // and the response count alone decides whether a read may be admitted.
  assign rsp_slot_free = (rsp_count < RSP_CW'(RSP_DEPTH));
  assign issue         = (state == ST_IDLE) && !cmd_empty && (head_wr || rsp_slot_free);
  assign rsp_push      = (state == ST_CAPTURE) && !rsp_full;

  assign out_cmd_ready = !cmd_full;
  assign out_rsp_valid = !rsp_empty;
  assign out_busy      = (state != ST_IDLE) || (cmd_count != '0);

  // Holding registers load only on the IDLE pop so mode/addr/data stay put for the
  // whole transfer while the master samples them.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state           <= ST_IDLE;
      out_tw_start    <= 1'b0;
      out_tw_mode_wr  <= 1'b0;
      out_tw_addr     <= '0;
      out_tw_wr_data  <= '0;
      tmo_cnt         <= '0;
      out_timeout_err <= 1'b0;
    end else begin
      out_tw_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            out_tw_mode_wr <= head_wr;
            out_tw_addr    <= cmd_head[DATA_BITS +: ADDR_BITS];
            out_tw_wr_data <= cmd_head[DATA_BITS-1:0];
            out_tw_start   <= 1'b1;
            state          <= ST_START;
          end
        end
        ST_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (in_tw_in_progress) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
            // Master never acknowledged: drop the command, no response.
            out_timeout_err <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!in_tw_in_progress) state <= out_tw_mode_wr ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .in_push      (cmd_push),
    .in_push_data ({in_cmd_wr, in_cmd_addr, in_cmd_data}),
    .in_pop       (issue),
    .out_head     (cmd_head),
    .out_count    (cmd_count),
    .out_full     (cmd_full),
    .out_empty    (cmd_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .in_push      (rsp_push),
    .in_push_data (in_tw_rd_data),
    .in_pop       (in_rsp_ready),
    .out_head     (out_rsp_data),
    .out_count    (rsp_count),
    .out_full     (rsp_full),
    .out_empty    (rsp_empty)
  );

endmodule

// File: tb/tb_threewire_cmd_queue.sv
// Purpose : randomized scoreboard bench for threewire_cmd_queue with a behavioural master/slave.
// Latency : n/a.
// Backpressure: response consumer randomly stalls; can be forced to hold off completely.
module tb_threewire_cmd_queue;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_cmd_valid = 1'b0;
  logic        out_cmd_ready;
  logic        in_cmd_wr = 1'b0;
  logic [9:0]  in_cmd_addr = '0;
  logic [31:0] in_cmd_data = '0;
  logic        out_rsp_valid;
  logic        in_rsp_ready = 1'b0;
  logic [31:0] out_rsp_data;
  logic        out_tw_start;
  logic        out_tw_mode_wr;
  logic [9:0]  out_tw_addr;
  logic [31:0] out_tw_wr_data;
  logic [31:0] in_tw_rd_data = '0;
  logic        in_tw_in_progress = 1'b0;
  logic        out_busy;
  logic        out_timeout_err;

  always #5 in_clk = ~in_clk;

  threewire_cmd_queue dut (
    .in_clk            (in_clk),
    .in_rst_n          (in_rst_n),
    .in_cmd_valid      (in_cmd_valid),
    .out_cmd_ready     (out_cmd_ready),
    .in_cmd_wr         (in_cmd_wr),
    .in_cmd_addr       (in_cmd_addr),
    .in_cmd_data       (in_cmd_data),
    .out_rsp_valid     (out_rsp_valid),
    .in_rsp_ready      (in_rsp_ready),
    .out_rsp_data      (out_rsp_data),
    .out_tw_start      (out_tw_start),
    .out_tw_mode_wr    (out_tw_mode_wr),
    .out_tw_addr       (out_tw_addr),
    .out_tw_wr_data    (out_tw_wr_data),
    .in_tw_rd_data     (in_tw_rd_data),
    .in_tw_in_progress (in_tw_in_progress),
    .out_busy          (out_busy),
    .out_timeout_err   (out_timeout_err)
  );

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } cmd_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] slave_mem [1024];
  logic [31:0] ref_mem   [1024];
  cmd_t        exp_cmd [$];
  logic [31:0] exp_rsp [$];
  bit          ignore_start = 0;
  bit          hold_busy = 0;
  bit          rsp_hold = 0;
  bit          m_act = 0;
  int          start_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 ^ i[31:0];
  endfunction

  // Stimulus samples/drives just after the falling edge, after master and monitor.
  task automatic step();
    @(negedge in_clk);
    #1;
  endtask

  // Behavioural master + slave register file; also checks each start against the
  // expected command order and that the held command stays stable for the transfer.
  initial begin : master
    cmd_t m;
    cmd_t e;
    int   m_wait;
    int   m_len;
    bit   stable;
    m = '0; m_wait = 0; m_len = 0; stable = 1;
    forever begin
      @(negedge in_clk);
      if (!in_rst_n) begin
        in_tw_in_progress = 1'b0;
        m_act = 0;
      end else begin
        if (out_tw_start) begin
          start_cnt++;
          if (exp_cmd.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            e = exp_cmd.pop_front();
            chk("start_cmd", {out_tw_mode_wr, out_tw_addr, out_tw_wr_data}, e);
          end
        end
        if (m_act) begin
          if ({out_tw_mode_wr, out_tw_addr, out_tw_wr_data} !== m) stable = 0;
          if (m_wait > 0) m_wait--;
          else if (!in_tw_in_progress) begin
            in_tw_in_progress = 1'b1;
            in_tw_rd_data = slave_mem[m.addr];
          end else if (m_len > 0 || hold_busy) begin
            if (m_len > 0) m_len--;
          end else begin
            in_tw_in_progress = 1'b0;
            m_act = 0;
            if (m.wr) slave_mem[m.addr] = m.data;
            chk("hold_stable", {63'd0, stable}, 1);
          end
        end else if (out_tw_start && !ignore_start) begin
          m = {out_tw_mode_wr, out_tw_addr, out_tw_wr_data};
          m_act = 1;
          stable = 1;
          m_wait = $urandom_range(0, 3);
          m_len = $urandom_range(1, 5);
        end
      end
    end
  end

  // Response consumer and scoreboard.
  initial begin : rsp_mon
    logic [31:0] e;
    forever begin
      @(negedge in_clk);
      in_rsp_ready = !rsp_hold && ($urandom_range(0, 3) != 0);
      if (in_rst_n && out_rsp_valid && in_rsp_ready) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", out_rsp_data, e);
        end
      end
    end
  end

  // Offer one command; on acceptance update the reference model of the register file.
  task automatic push_cmd(input logic wr, input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    in_cmd_valid = 1'b1; in_cmd_wr = wr; in_cmd_addr = a; in_cmd_data = d;
    while (!out_cmd_ready && n < 2000) begin step(); n++; end
    if (n >= 2000) chk("push_timeout", 1, 0);
    else begin
      exp_cmd.push_back({wr, a, d});
      if (!ignore_start) begin
        if (wr) ref_mem[a] = d;
        else exp_rsp.push_back(ref_mem[a]);
      end
    end
    step();
    in_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((out_busy || m_act || exp_rsp.size() != 0 || out_rsp_valid) && n < 5000) begin
      step(); n++;
    end
    chk({name, "_drain_timeout"}, {63'd0, n >= 5000}, 0);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n = 0;
    while (in_tw_in_progress !== lvl && n < 200) begin step(); n++; end
    chk({name, "_wait_busy"}, {63'd0, n >= 200}, 0);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_cmd_ready"},   out_cmd_ready, 1);
    chk({p, "_rsp_valid"},   out_rsp_valid, 0);
    chk({p, "_rsp_data"},    out_rsp_data, 0);
    chk({p, "_tw_start"},    out_tw_start, 0);
    chk({p, "_tw_mode"},     out_tw_mode_wr, 0);
    chk({p, "_tw_addr"},     out_tw_addr, 0);
    chk({p, "_tw_wr_data"},  out_tw_wr_data, 0);
    chk({p, "_busy"},        out_busy, 0);
    chk({p, "_timeout_err"}, out_timeout_err, 0);
  endtask

  initial begin : stim
    int s0;
    int n;
    for (int i = 0; i < 1024; i++) begin
      slave_mem[i] = init_val(i);
      ref_mem[i]   = init_val(i);
    end
    repeat (3) step();
    check_reset("rst");
    in_rst_n = 1'b1;
    step();

    // Single write, with first-command latency.
    s0 = start_cnt;
    push_cmd(1'b1, 10'h155, 32'hDEADBEEF);
    chk("lat_t1_start", out_tw_start, 0);
    chk("lat_t1_addr", out_tw_addr, 0);
    step();
    chk("lat_t2_start", out_tw_start, 1);
    chk("lat_t2_addr", out_tw_addr, 10'h155);
    chk("lat_t2_mode", out_tw_mode_wr, 1);
    drain("wr");
    chk("wr_one_start", start_cnt - s0, 1);
    chk("wr_slave_reg", slave_mem[10'h155], 32'hDEADBEEF);
    chk("wr_no_rsp", out_rsp_valid, 0);

    // Single read held in the response FIFO until released.
    slave_mem[10'h2AA] = 32'h12345678;
    ref_mem[10'h2AA]   = 32'h12345678;
    rsp_hold = 1;
    push_cmd(1'b0, 10'h2AA, 32'h0);
    wait_busy(1'b1, "rd_rise");
    wait_busy(1'b0, "rd_fall");
    n = 0;
    while (!out_rsp_valid && n < 50) begin step(); n++; end
    chk("rsp_latency", n, 2);
    repeat (5) step();
    chk("rd_rsp_held", out_rsp_valid, 1);
    chk("rd_rsp_data", out_rsp_data, 32'h12345678);
    rsp_hold = 0;
    drain("rd");
    chk("rd_popped", out_rsp_valid, 0);

    // Stall the FSM and fill the command FIFO; a ninth push must be refused.
    hold_busy = 1;
    push_cmd(1'b1, 10'd3, $urandom);
    wait_busy(1'b1, "stall");
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready", out_cmd_ready, 1);
      push_cmd(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
    end
    chk("full_ready", out_cmd_ready, 0);
    in_cmd_valid = 1'b1; in_cmd_wr = 1'b1; in_cmd_addr = 10'h3FF; in_cmd_data = 32'hBAD;
    repeat (4) step();
    chk("ninth_refused", out_cmd_ready, 0);
    in_cmd_valid = 1'b0;
    hold_busy = 0;
    drain("stall");

    // Six reads with the consumer stalled: only four may issue.
    rsp_hold = 1;
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 10'($urandom_range(0, 15)), 32'h0);
    repeat (150) step();
    chk("rspfull_starts", start_cnt - s0, 4);
    chk("rspfull_valid", out_rsp_valid, 1);
    chk("rspfull_busy", out_busy, 1);
    rsp_hold = 0;
    drain("rspfull");
    chk("rspfull_all_starts", start_cnt - s0, 6);

    // Master never acknowledges: timeout after the wait window, next command proceeds.
    ignore_start = 1;
    chk("tmo_err_clear", out_timeout_err, 0);
    push_cmd(1'b1, 10'd7, 32'h77);
    n = 0;
    while (!out_tw_start && n < 20) begin step(); n++; end
    chk("tmo_start_seen", out_tw_start, 1);
    n = 0;
    while (!out_timeout_err && n < 100) begin step(); n++; end
    chk("tmo_cycles", n, 16);
    ignore_start = 0;
    push_cmd(1'b0, 10'd7, 32'h0);
    drain("tmo");
    chk("tmo_err_sticky", out_timeout_err, 1);
    chk("tmo_write_dropped", slave_mem[7], init_val(7));

    // Reset during WAIT_DONE of a read.
    push_cmd(1'b0, 10'd9, 32'h0);
    wait_busy(1'b1, "rst_rd");
    step();
    chk("pre_rst_busy", out_busy, 1);
    in_rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_rsp.delete();
    exp_cmd.delete();
    repeat (2) step();
    in_rst_n = 1'b1;
    repeat (20) step();
    chk("no_rsp_after_rst", out_rsp_valid, 0);

    // Randomized mix over a small address window so reads hit earlier writes.
    for (int i = 0; i < 60; i++) begin
      push_cmd(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 3)) step();
    end
    drain("rand");
    chk("rand_cmd_queue_empty", exp_cmd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
